// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants: opcodes, ALU control codes, immediate formats.
package riscv_pkg;

   localparam int unsigned DEF_XLEN = 32;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10
   } imm_src_t;

   // funct3 -> ALU op; sub_en selects sub for funct3 000 (R-type funct7[5] only)
   function automatic logic [2:0] alu_decode(input logic [2:0] funct3, input logic sub_en);
      logic [2:0] op;
      case (funct3)
         3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
         3'b010:  op = ALU_SLT;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/decode_cycle_reg_file.sv
// 32x32 register file: two combinational read ports, one write port, x0 reads zero.
// Optional build macro REGFILE_BYPASS_EN: same-cycle write data is forwarded to reads.
module reg_file
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN  = DEF_XLEN,
   parameter int unsigned NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      a1,
   input  logic [4:0]      a2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd
);

   logic [XLEN-1:0] regs [NREGS];

   // Write port; x0 is never written so it stays at its reset value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   // Read port 1
   always_comb begin
      rd1 = (a1 == '0) ? '0 : regs[a1];
`ifdef REGFILE_BYPASS_EN
      if (we && (wa != '0) && (wa == a1)) rd1 = wd;
`endif
   end

   // Read port 2
   always_comb begin
      rd2 = (a2 == '0) ? '0 : regs[a2];
`ifdef REGFILE_BYPASS_EN
      if (we && (wa != '0) && (wa == a2)) rd2 = wd;
`endif
   end

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: control decode, register read, immediate extend, D/E pipeline register.
// Build macro REGFILE_BYPASS_EN enables same-cycle writeback-to-read forwarding in reg_file.
module decode_cycle
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN  = DEF_XLEN,
   parameter int unsigned NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            FlushE,
   input  logic            RegWriteW,
   input  logic [4:0]      RDW,
   input  logic [XLEN-1:0] ResultW,
   output logic            RegWriteE,
   output logic            ALUSrcE,
   output logic            MemWriteE,
   output logic            ResultSrcE,
   output logic            BranchE,
   output logic [2:0]      ALUControlE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [4:0]      RDE,
   output logic [4:0]      RS1E,
   output logic [4:0]      RS2E,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E
);

   logic            reg_write, alu_src, mem_write, result_src, branch;
   logic [2:0]      alu_ctl;
   imm_src_t        imm_src;
   logic [XLEN-1:0] imm_ext, rd1, rd2;

   reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_reg_file (
      .clk (clk),
      .rst (rst),
      .a1  (InstrD[19:15]),
      .a2  (InstrD[24:20]),
      .rd1 (rd1),
      .rd2 (rd2),
      .we  (RegWriteW),
      .wa  (RDW),
      .wd  (ResultW)
   );

   // Main control decode from opcode; unknown opcodes decode as NOP
   always_comb begin
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      mem_write  = 1'b0;
      result_src = 1'b0;
      branch     = 1'b0;
      alu_ctl    = ALU_ADD;
      imm_src    = IMM_I;
      case (InstrD[6:0])
         OP_LW: begin
            reg_write  = 1'b1;
            alu_src    = 1'b1;
            result_src = 1'b1;
         end
         OP_SW: begin
            mem_write = 1'b1;
            alu_src   = 1'b1;
            imm_src   = IMM_S;
         end
         OP_R: begin
            reg_write = 1'b1;
            alu_ctl   = alu_decode(InstrD[14:12], InstrD[30]);
         end
         OP_I: begin
            reg_write = 1'b1;
            alu_src   = 1'b1;
            alu_ctl   = alu_decode(InstrD[14:12], 1'b0);
         end
         OP_BEQ: begin
            branch  = 1'b1;
            alu_ctl = ALU_SUB;
            imm_src = IMM_B;
         end
         default: ;
      endcase
   end

   // Immediate extraction and sign extension
   always_comb begin
      case (imm_src)
         IMM_S:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
         default: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      endcase
   end

   // D/E pipeline register; flush loads an all-zero bubble ahead of new data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || FlushE) begin
         if (!rst || FlushE) begin
            RegWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            MemWriteE   <= 1'b0;
            ResultSrcE  <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            RDE         <= '0;
            RS1E        <= '0;
            RS2E        <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
         end
      end else begin
         RegWriteE   <= reg_write;
         ALUSrcE     <= alu_src;
         MemWriteE   <= mem_write;
         ResultSrcE  <= result_src;
         BranchE     <= branch;
         ALUControlE <= alu_ctl;
         RD1E        <= rd1;
         RD2E        <= rd2;
         ImmExtE     <= imm_ext;
         RDE         <= InstrD[11:7];
         RS1E        <= InstrD[19:15];
         RS2E        <= InstrD[24:20];
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
      end
   end

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: table-driven vectors through a scoreboard,
// plus hand-written reset sequences. Honours REGFILE_BYPASS_EN when defined.
module tb_decode_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
   logic        FlushE, RegWriteW;
   logic [4:0]  RDW;
   logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]  RDE, RS1E, RS2E;

   decode_cycle #(.XLEN(32), .NREGS(32)) dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
      .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
      .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
      .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RDE(RDE), .RS1E(RS1E),
      .RS2E(RS2E), .PCE(PCE), .PCPlus4E(PCPlus4E)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        flush;
      logic        wen;
      logic [4:0]  rdw;
      logic [31:0] wd;
      logic        rw, alusrc, mw, rsrc, br;
      logic [2:0]  alu;
      logic [31:0] imm;
   } vec_t;

   typedef struct {
      logic        rw, alusrc, mw, rsrc, br;
      logic [2:0]  alu;
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] pc, pcp4;
   } out_t;

   int unsigned tests = 0;
   int unsigned fails = 0;
   logic [31:0] mdl [32];
   out_t        sb [$];
   vec_t        tbl [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, ".ctrl"}, {9'd0, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE,
                           ALUControlE, RDE, RS1E, RS2E}, 32'd0);
      chk({pfx, ".RD1E"}, RD1E, 32'd0);
      chk({pfx, ".RD2E"}, RD2E, 32'd0);
      chk({pfx, ".ImmExtE"}, ImmExtE, 32'd0);
      chk({pfx, ".PCE"}, PCE, 32'd0);
      chk({pfx, ".PCPlus4E"}, PCPlus4E, 32'd0);
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input logic flush, input logic wen,
                               input logic [4:0] rdw, input logic [31:0] wd,
                               input logic [4:0] ctl, input logic [2:0] alu,
                               input logic [31:0] imm);
      vec_t v;
      v.instr = instr; v.pc = 32'h1000 + 32'(tbl.size() * 4); v.flush = flush;
      v.wen = wen; v.rdw = rdw; v.wd = wd;
      {v.rw, v.alusrc, v.mw, v.rsrc, v.br} = ctl;
      v.alu = alu; v.imm = imm;
      return v;
   endfunction

   function automatic logic [31:0] rd_model(input logic [4:0] r, input vec_t v);
      if (r == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
      if (v.wen && v.rdw == r) return v.wd;
`endif
      return mdl[r];
   endfunction

   function automatic out_t model(input vec_t v);
      out_t e;
      e.rw = v.rw; e.alusrc = v.alusrc; e.mw = v.mw; e.rsrc = v.rsrc; e.br = v.br;
      e.alu = v.alu; e.imm = v.imm;
      e.rd1 = rd_model(v.instr[19:15], v);
      e.rd2 = rd_model(v.instr[24:20], v);
      e.rd = v.instr[11:7]; e.rs1 = v.instr[19:15]; e.rs2 = v.instr[24:20];
      e.pc = v.pc; e.pcp4 = v.pc + 32'd4;
      if (v.flush) begin
         e.rw = 0; e.alusrc = 0; e.mw = 0; e.rsrc = 0; e.br = 0; e.alu = '0;
         e.rd1 = '0; e.rd2 = '0; e.imm = '0; e.rd = '0; e.rs1 = '0; e.rs2 = '0;
         e.pc = '0; e.pcp4 = '0;
      end
      return e;
   endfunction

   task automatic check_out(input out_t e, input string p);
      chk({p, ".RegWriteE"}, {31'd0, RegWriteE}, {31'd0, e.rw});
      chk({p, ".ALUSrcE"}, {31'd0, ALUSrcE}, {31'd0, e.alusrc});
      chk({p, ".MemWriteE"}, {31'd0, MemWriteE}, {31'd0, e.mw});
      chk({p, ".ResultSrcE"}, {31'd0, ResultSrcE}, {31'd0, e.rsrc});
      chk({p, ".BranchE"}, {31'd0, BranchE}, {31'd0, e.br});
      chk({p, ".ALUControlE"}, {29'd0, ALUControlE}, {29'd0, e.alu});
      chk({p, ".RD1E"}, RD1E, e.rd1);
      chk({p, ".RD2E"}, RD2E, e.rd2);
      chk({p, ".ImmExtE"}, ImmExtE, e.imm);
      chk({p, ".RDE/RS1E/RS2E"}, {17'd0, RDE, RS1E, RS2E}, {17'd0, e.rd, e.rs1, e.rs2});
      chk({p, ".PCE"}, PCE, e.pc);
      chk({p, ".PCPlus4E"}, PCPlus4E, e.pcp4);
   endtask

   task automatic apply(input vec_t v, input string p);
      out_t e;
      @(negedge clk);
      InstrD = v.instr; PCD = v.pc; PCPlus4D = v.pc + 32'd4; FlushE = v.flush;
      RegWriteW = v.wen; RDW = v.rdw; ResultW = v.wd;
      sb.push_back(model(v));
      if (v.wen && v.rdw != 5'd0) mdl[v.rdw] = v.wd;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({p, ".scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check_out(e, p);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      // ctl = {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch}
      tbl.push_back(mk(32'h00500093, 0, 0, 5'd0, 32'h0,        5'b11000, 3'b000, 32'h00000005)); // addi x1,x0,5
      tbl.push_back(mk(32'h00000000, 0, 1, 5'd2, 32'hDEADBEEF, 5'b00000, 3'b000, 32'h00000000)); // nop + wb x2
      tbl.push_back(mk(32'h00210233, 0, 0, 5'd0, 32'h0,        5'b10000, 3'b000, 32'h00000002)); // add x4,x2,x2
      tbl.push_back(mk(32'h00000000, 0, 1, 5'd0, 32'h00001234, 5'b00000, 3'b000, 32'h00000000)); // wb x0 ignored
      tbl.push_back(mk(32'h00000333, 0, 0, 5'd0, 32'h0,        5'b10000, 3'b000, 32'h00000000)); // add x6,x0,x0
      tbl.push_back(mk(32'hFFC0A383, 0, 0, 5'd0, 32'h0,        5'b11010, 3'b000, 32'hFFFFFFFC)); // lw x7,-4(x1)
      tbl.push_back(mk(32'hFE112E23, 0, 0, 5'd0, 32'h0,        5'b01100, 3'b000, 32'hFFFFFFFC)); // sw
      tbl.push_back(mk(32'h40110433, 0, 0, 5'd0, 32'h0,        5'b10000, 3'b001, 32'h00000401)); // sub
      tbl.push_back(mk(32'h0020A4B3, 0, 0, 5'd0, 32'h0,        5'b10000, 3'b101, 32'h00000002)); // slt
      tbl.push_back(mk(32'h0020E533, 0, 0, 5'd0, 32'h0,        5'b10000, 3'b011, 32'h00000002)); // or
      tbl.push_back(mk(32'hFFF0F593, 0, 0, 5'd0, 32'h0,        5'b11000, 3'b010, 32'hFFFFFFFF)); // andi -1
      tbl.push_back(mk(32'h40008613, 0, 0, 5'd0, 32'h0,        5'b11000, 3'b000, 32'h00000400)); // addi, bit30 set
      tbl.push_back(mk(32'h002096B3, 0, 0, 5'd0, 32'h0,        5'b10000, 3'b000, 32'h00000002)); // funct3 001 -> add
      tbl.push_back(mk(32'h00208463, 0, 0, 5'd0, 32'h0,        5'b00001, 3'b001, 32'h00000008)); // beq +8
      tbl.push_back(mk(32'hFE208EE3, 0, 0, 5'd0, 32'h0,        5'b00001, 3'b001, 32'hFFFFFFFC)); // beq -4
      tbl.push_back(mk(32'h123450EF, 0, 0, 5'd0, 32'h0,        5'b00000, 3'b000, 32'h00000123)); // jal -> nop
      tbl.push_back(mk(32'h00208463, 1, 1, 5'd3, 32'hCAFEF00D, 5'b00001, 3'b001, 32'h00000008)); // flushed beq + wb x3
      tbl.push_back(mk(32'h00018733, 0, 0, 5'd0, 32'h0,        5'b10000, 3'b000, 32'h00000000)); // add x14,x3,x0
      tbl.push_back(mk(32'h000287B3, 0, 1, 5'd5, 32'h0000A5A5, 5'b10000, 3'b000, 32'h00000000)); // same-cycle x5
      tbl.push_back(mk(32'h000287B3, 0, 0, 5'd0, 32'h0,        5'b10000, 3'b000, 32'h00000000)); // x5 next cycle

      // Reset held low across an edge: outputs stay zero
      rst = 1'b0; InstrD = 32'h00500093; PCD = 32'h100; PCPlus4D = 32'h104;
      FlushE = 1'b0; RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'h0;
      #2;
      chk_zero("reset.async");
      @(posedge clk); #1;
      chk_zero("reset.held");
      @(negedge clk);
      rst = 1'b1;

      foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

      // Reset in mid-operation: in-flight instruction and register contents discarded
      @(negedge clk);
      InstrD = 32'h00500093; PCD = 32'h200; PCPlus4D = 32'h204; FlushE = 1'b0;
      RegWriteW = 1'b1; RDW = 5'd6; ResultW = 32'h77;
      @(posedge clk); #1;
      chk("midrst.pre.RegWriteE", {31'd0, RegWriteE}, 32'd1);
      RegWriteW = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk_zero("midrst");
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      @(negedge clk);
      rst = 1'b1;
      apply(mk(32'h00030833, 0, 0, 5'd0, 32'h0, 5'b10000, 3'b000, 32'h0), "midrst.x6");
      apply(mk(32'h00210233, 0, 0, 5'd0, 32'h0, 5'b10000, 3'b000, 32'h2), "midrst.x2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
